keypad_debouncer: RTL and testbench

Front-end producer for the lock's digit interface. Takes the raw, asynchronous, bouncing 10-line keypad and delivers the digit stream the lock controller consumes: a clean BCD digit plus a single-cycle strobe per physical press. The block synchronises, debounces and validates the keypad, so the downstream controller sees exactly one load event per press. Simultaneous multi-key presses and release bounce never generate a digit.

---
 rtl/keypad_debouncer.sv | 140 ++++++++++++++
 tb/tb_keypad_debouncer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer.sv
// Keypad front end: synchronise, debounce and validate ten raw key lines
// into one BCD digit strobe per physical single-key press.
module keypad_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       hard_rst_n,
  input  logic [9:0] keypad,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       press_active,
  output logic       multi_press,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [9:0]       sync1_q, s_q;
  logic [9:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [3:0]       digit_q, digit_d;
  logic             dv_q, dv_d;
  logic             mp_q, mp_d;
  logic [7:0]       pc_q, pc_d;

  logic             cand_onehot;
  logic [3:0]       cand_idx;

  // A pattern is one-hot when non-zero and clearing its lowest set bit empties it.
  assign cand_onehot = (cand_q != 10'd0) &&
                       ((cand_q & (cand_q - 10'd1)) == 10'd0);

  always_comb begin
    cand_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (cand_q[i]) cand_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    mp_d    = 1'b0;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (s_q != 10'd0) begin
          state_d = PRESS_DB;
          cand_d  = s_q;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (s_q != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          if (cand_onehot) begin
            digit_d = cand_idx;
            dv_d    = 1'b1;
            pc_d    = pc_q + 8'd1;
            acc_d   = 1'b1;
          end else begin
            mp_d  = 1'b1;
            acc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (s_q == 10'd0) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        // Chatter during release returns to the same press.
        if (s_q != 10'd0) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          acc_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      s_q     <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      digit_q <= '0;
      dv_q    <= 1'b0;
      mp_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= keypad;
      s_q     <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      mp_q    <= mp_d;
      pc_q    <= pc_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = dv_q;
  assign multi_press  = mp_q;
  assign press_count  = pc_q;
  assign press_active = acc_q &&
                        ((state_q == HELD) || (state_q == RELEASE_DB));

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer with DEBOUNCE_CYCLES = 4.
module tb_keypad_debouncer;

  localparam int D = 4;
  localparam int LAT = D + 3;

  logic       clk;
  logic       hard_rst_n;
  logic [9:0] keypad;
  logic [3:0] digit;
  logic       digit_valid;
  logic       press_active;
  logic       multi_press;
  logic [7:0] press_count;

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .hard_rst_n(hard_rst_n),
    .keypad(keypad),
    .digit(digit),
    .digit_valid(digit_valid),
    .press_active(press_active),
    .multi_press(multi_press),
    .press_count(press_count)
  );

  typedef struct {
    bit         multi;
    logic [3:0] dig;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_cnt = 0;
  logic [3:0] exp_dig = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Expected strobe: kind 1 = digit, kind 2 = multi-key.
  task automatic push_exp(input int kind, input logic [3:0] d,
                          input int due);
    exp_t e;
    if (kind == 1) begin
      exp_cnt = exp_cnt + 8'd1;
      exp_dig = d;
    end
    e.multi = (kind == 2);
    e.dig   = exp_dig;
    e.cnt   = exp_cnt;
    e.due   = due;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (hard_rst_n && (digit_valid || multi_press)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe dv=%0b mp=%0b digit=%0d cycle=%0d",
                 digit_valid, multi_press, digit, cyc);
      end else begin
        mon_e = q.pop_front();
        check("strobe_multi", int'(multi_press), int'(mon_e.multi));
        check("strobe_dv", int'(digit_valid), int'(!mon_e.multi));
        check("strobe_digit", int'(digit), int'(mon_e.dig));
        check("strobe_count", int'(press_count), int'(mon_e.cnt));
        check("strobe_time", cyc, mon_e.due);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digit"}, int'(digit), 0);
    check({tag, "_dv"}, int'(digit_valid), 0);
    check({tag, "_active"}, int'(press_active), 0);
    check({tag, "_multi"}, int'(multi_press), 0);
    check({tag, "_count"}, int'(press_count), 0);
  endtask

  initial begin
    int t;
    logic [9:0] pat;
    keypad = '0;
    hard_rst_n = 1'b0;
    wait_n(3);
    check_all_zero("reset");
    hard_rst_n = 1'b1;
    wait_n(2);

    // Clean press of key 3
    t = cyc;
    keypad = 10'b0000001000;
    push_exp(1, 4'd3, t + LAT);
    wait_n(20);
    keypad = '0;
    wait_n(6);
    check("clean_active_late", int'(press_active), 1);
    wait_n(1);
    check("clean_active_end", int'(press_active), 0);
    wait_n(5);

    // Key 5 bouncing, then held
    for (int k = 0; k < 6; k++) begin
      keypad = (k % 2 == 0) ? 10'b0000100000 : 10'b0;
      wait_n(2);
    end
    t = cyc;
    keypad = 10'b0000100000;
    push_exp(1, 4'd5, t + LAT);
    wait_n(15);
    keypad = '0;
    wait_n(12);

    // Key 7 with release chatter
    t = cyc;
    keypad = 10'b0010000000;
    push_exp(1, 4'd7, t + LAT);
    wait_n(15);
    check("rel_active_held", int'(press_active), 1);
    keypad = '0;
    wait_n(1);
    keypad = 10'b0010000000;
    wait_n(1);
    keypad = '0;
    wait_n(6);
    check("rel_active_late", int'(press_active), 1);
    wait_n(1);
    check("rel_active_end", int'(press_active), 0);
    wait_n(5);

    // Keys 2 and 9 together
    t = cyc;
    keypad = 10'b1000000100;
    push_exp(2, 4'd0, t + LAT);
    wait_n(12);
    check("multi_active", int'(press_active), 0);
    check("multi_digit", int'(digit), 7);
    check("multi_count", int'(press_count), 3);
    keypad = '0;
    wait_n(12);

    // Key 1, then key 4 added, key 1 dropped, all released
    t = cyc;
    keypad = 10'b0000000010;
    push_exp(1, 4'd1, t + LAT);
    wait_n(12);
    keypad = 10'b0000010010;
    wait_n(8);
    keypad = 10'b0000010000;
    wait_n(6);
    check("add_active", int'(press_active), 1);
    keypad = '0;
    wait_n(12);
    check("add_count", int'(press_count), 4);

    // Reset mid-PRESS_DB
    keypad = 10'b0100000000;
    wait_n(4);
    hard_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    keypad = '0;
    wait_n(3);
    hard_rst_n = 1'b1;
    exp_cnt = '0;
    exp_dig = '0;
    wait_n(20);
    check("postrst_count", int'(press_count), 0);

    // 256 presses wrap the counter
    for (int i = 0; i < 256; i++) begin
      pat = 10'd1 << (i % 10);
      t = cyc;
      keypad = pat;
      push_exp(1, 4'(i % 10), t + LAT);
      wait_n(10);
      keypad = '0;
      wait_n(10);
    end
    check("wrap_count", int'(press_count), 0);
    check("wrap_digit", int'(digit), 5);

    wait_n(5);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
